// File: rtl/bsg_test_node_master.sv
// Master end of the test-node ring: issues LFSR-payload requests to one
// client, consumes and checks its responses, and folds them into a signature.
module bsg_test_node_master #(
    parameter int          ring_width_p      = 80,
    parameter int          master_id_p       = 0,
    parameter int          client_id_p       = 0,
    parameter int          num_tests_p       = 16,
    parameter int          max_outstanding_p = 4,
    parameter logic [63:0] seed_p            = 64'h1,
    parameter int          timeout_p         = 1024
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    en_i,
    output logic                    v_o,
    output logic [ring_width_p-1:0] data_o,
    input  logic                    yumi_i,
    input  logic                    v_i,
    input  logic [ring_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [31:0]             signature_o,
    output logic [15:0]             sent_count_o,
    output logic [15:0]             recv_count_o
);

    localparam logic [3:0]  client_lp   = 4'(client_id_p);
    localparam logic [15:0] num_tests_lp = 16'(num_tests_p);
    localparam logic [3:0]  max_out_lp  = 4'(max_outstanding_p);
    localparam logic [31:0] timer_max_lp = 32'(timeout_p - 1);
    localparam logic [63:0] lfsr_mask_lp = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [63:0]             lfsr_q, lfsr_d;
    logic [ring_width_p-1:0] data_q, data_d;
    logic [15:0]             sent_q, sent_d;
    logic [15:0]             recv_q, recv_d;
    logic [3:0]              out_q, out_d;
    logic [31:0]             timer_q, timer_d;
    logic [31:0]             sig_q, sig_d;
    logic                    error_q, error_d;

    logic send;
    logic accept;
    logic bad_hdr;
    logic bad_pad;
    logic timeout;

    // The master id is informational only; the reserved bit is never checked.
    logic unused_bits;
    assign unused_bits = ^{data_i[ring_width_p-5], 4'(master_id_p)};

    // Galois right-shift step, taps x^64+x^63+x^61+x^60+1.
    function automatic logic [63:0] lfsr_step(input logic [63:0] l);
        return {1'b0, l[63:1]} ^ (l[0] ? lfsr_mask_lp : 64'h0);
    endfunction

    // Request packet: client header, reserved zero, zero pad, 64-bit payload.
    function automatic logic [ring_width_p-1:0] make_pkt(input logic [63:0] p);
        return {client_lp, 1'b0, {(ring_width_p-69){1'b0}}, p};
    endfunction

    assign v_o          = (state_q == S_RUN) && (sent_q < num_tests_lp) && (out_q < max_out_lp);
    assign ready_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o       = (state_q == S_DONE);
    assign data_o       = data_q;
    assign error_o      = error_q;
    assign signature_o  = sig_q;
    assign sent_count_o = sent_q;
    assign recv_count_o = recv_q;

    assign send    = v_o & yumi_i;
    assign accept  = v_i & ready_o;
    assign bad_hdr = data_i[ring_width_p-1 -: 4] != client_lp;
    assign bad_pad = |data_i[ring_width_p-6:32];

    // Next-state, counters, signature, outstanding tracking and timeout.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        data_d  = data_q;
        sent_d  = sent_q;
        recv_d  = recv_q;
        out_d   = out_q;
        timer_d = timer_q;
        sig_d   = sig_q;
        error_d = error_q;
        timeout = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (en_i) begin
                    state_d = S_RUN;
                    lfsr_d  = seed_p;
                    data_d  = make_pkt(seed_p);
                    sent_d  = '0;
                    recv_d  = '0;
                    out_d   = '0;
                    timer_d = '0;
                    sig_d   = '0;
                    error_d = 1'b0;
                end
            end
            S_RUN, S_DRAIN: begin
                if (send) begin
                    sent_d = sent_q + 16'd1;
                    lfsr_d = lfsr_step(lfsr_q);
                    data_d = make_pkt(lfsr_step(lfsr_q));
                end
                if (accept) begin
                    recv_d = recv_q + 16'd1;
                    sig_d  = {sig_q[30:0], sig_q[31]} ^ data_i[31:0];
                    if (bad_hdr || bad_pad || (out_q == 4'd0)) begin
                        error_d = 1'b1;
                    end
                end
                // Same-cycle send and accept cancel; never decrement below 0.
                if (send && !accept) begin
                    out_d = out_q + 4'd1;
                end else if (accept && !send && (out_q != 4'd0)) begin
                    out_d = out_q - 4'd1;
                end
                if (accept || (out_q == 4'd0)) begin
                    timer_d = '0;
                end else if (timer_q == timer_max_lp) begin
                    timeout = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end

                if (timeout) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else if ((state_q == S_RUN) && (sent_q == num_tests_lp)) begin
                    state_d = S_DRAIN;
                end else if ((state_q == S_DRAIN) && (recv_q == sent_q)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            lfsr_q  <= seed_p;
            data_q  <= '0;
            sent_q  <= '0;
            recv_q  <= '0;
            out_q   <= '0;
            timer_q <= '0;
            sig_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
            sent_q  <= sent_d;
            recv_q  <= recv_d;
            out_q   <= out_d;
            timer_q <= timer_d;
            sig_q   <= sig_d;
            error_q <= error_d;
        end
    end

endmodule

// File: tb/tb_bsg_test_node_master.sv
// Directed bench for bsg_test_node_master: loopback, backpressure,
// simultaneous send/accept, bad responses, timeout, restart and reset.
module tb_bsg_test_node_master;

    localparam logic [63:0] SEED = 64'h1;
    localparam logic [3:0]  CID  = 4'd3;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        en_i = 1'b0;
    logic        v_o;
    logic [79:0] data_o;
    logic        yumi_i = 1'b0;
    logic        v_i = 1'b0;
    logic [79:0] data_i = '0;
    logic        ready_o;
    logic        done_o;
    logic        error_o;
    logic [31:0] signature_o;
    logic [15:0] sent_count_o;
    logic [15:0] recv_count_o;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] m_lfsr;
    logic [31:0] m_sig;
    logic [63:0] last_payload;

    bsg_test_node_master #(
        .ring_width_p(80), .master_id_p(0), .client_id_p(3), .num_tests_p(4),
        .max_outstanding_p(2), .seed_p(SEED), .timeout_p(16)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i),
        .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
        .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .done_o(done_o), .error_o(error_o), .signature_o(signature_o),
        .sent_count_o(sent_count_o), .recv_count_o(recv_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    function automatic logic [63:0] lfsr_step(input logic [63:0] l);
        logic [63:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 64'hD800_0000_0000_0000;
        return n;
    endfunction

    function automatic logic [79:0] echo(input logic [31:0] low);
        return {CID, 1'b0, 43'b0, low};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_run();
        en_i = 1'b1;
        tick();
        en_i = 1'b0;
        m_lfsr = SEED;
        m_sig  = '0;
    endtask

    task automatic send_one();
        check("req_v", 80'(v_o), 80'(1'b1));
        check("req_data", data_o, {CID, 1'b0, 11'b0, m_lfsr});
        last_payload = m_lfsr;
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic respond(input logic [79:0] pkt);
        v_i    = 1'b1;
        data_i = pkt;
        tick();
        v_i    = 1'b0;
        m_sig  = {m_sig[30:0], m_sig[31]} ^ pkt[31:0];
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_o && n < 20) begin
            tick();
            n++;
        end
        check(tag, 80'(done_o), 80'(1'b1));
    endtask

    initial begin
        int cnt;
        reset_i = 1'b1;
        #2 reset_i = 1'b0;
        #1;
        check("rst_v", 80'(v_o), 80'(0));
        check("rst_data", data_o, 80'(0));
        check("rst_ready", 80'(ready_o), 80'(0));
        check("rst_done", 80'(done_o), 80'(0));
        check("rst_sig", 80'(signature_o), 80'(0));
        tick();
        #2 reset_i = 1'b1;
        tick();

        // Loopback, one request then its echo at a time.
        start_run();
        check("first_payload", 80'(data_o[63:0]), 80'(64'h1));
        send_one();
        respond(echo(last_payload[31:0]));
        check("second_payload", 80'(data_o[63:0]), 80'(64'hD800_0000_0000_0000));
        for (int i = 0; i < 3; i++) begin
            send_one();
            respond(echo(last_payload[31:0]));
        end
        wait_done("loop_done");
        check("loop_err", 80'(error_o), 80'(0));
        check("loop_sent", 80'(sent_count_o), 80'(4));
        check("loop_recv", 80'(recv_count_o), 80'(4));
        check("loop_sig_hand", 80'(signature_o), 80'(32'h8));
        check("loop_sig_model", 80'(signature_o), 80'(m_sig));
        // Responses in DONE are refused.
        check("done_ready", 80'(ready_o), 80'(0));
        v_i = 1'b1; data_i = echo(32'h55); tick(); v_i = 1'b0;
        check("done_no_accept", 80'(recv_count_o), 80'(4));

        // Restart with backpressure.
        start_run();
        check("restart_done", 80'(done_o), 80'(0));
        check("restart_sent", 80'(sent_count_o), 80'(0));
        check("restart_recv", 80'(recv_count_o), 80'(0));
        check("restart_sig", 80'(signature_o), 80'(0));
        for (int i = 0; i < 10; i++) tick();
        check("hold_data", data_o, {CID, 1'b0, 11'b0, SEED});
        send_one();
        send_one();
        check("bp_v_low", 80'(v_o), 80'(0));
        yumi_i = 1'b1; tick(); yumi_i = 1'b0;
        check("illegal_yumi", 80'(sent_count_o), 80'(2));
        respond(echo(32'h1));
        respond(echo(32'h0));
        check("bp_v_back", 80'(v_o), 80'(1));
        send_one();
        send_one();
        respond(echo(32'h0));
        respond(echo(32'h0));
        wait_done("bp_done");
        check("bp_err", 80'(error_o), 80'(0));
        check("restart_same_sig", 80'(signature_o), 80'(32'h8));

        // Simultaneous send and accept every cycle.
        start_run();
        send_one();
        for (int i = 0; i < 3; i++) begin
            check("sim_v", 80'(v_o), 80'(1));
            check("sim_data", data_o, {CID, 1'b0, 11'b0, m_lfsr});
            yumi_i = 1'b1;
            v_i    = 1'b1;
            data_i = echo(last_payload[31:0]);
            m_sig  = {m_sig[30:0], m_sig[31]} ^ last_payload[31:0];
            last_payload = m_lfsr;
            tick();
            yumi_i = 1'b0;
            v_i    = 1'b0;
            m_lfsr = lfsr_step(m_lfsr);
        end
        respond(echo(last_payload[31:0]));
        wait_done("sim_done");
        check("sim_err", 80'(error_o), 80'(0));
        check("sim_recv", 80'(recv_count_o), 80'(4));
        check("sim_sig", 80'(signature_o), 80'(m_sig));

        // Bad header and non-zero padding.
        start_run();
        for (int i = 0; i < 4; i++) begin
            logic [79:0] pkt;
            send_one();
            pkt = echo(32'h1234_5678 + i);
            if (i == 1) pkt[79:76] = 4'hF;
            if (i == 2) pkt[40] = 1'b1;
            respond(pkt);
            if (i == 0) check("bad_err_before", 80'(error_o), 80'(0));
            if (i == 1) check("bad_hdr_err", 80'(error_o), 80'(1));
        end
        wait_done("bad_done");
        check("bad_err_sticky", 80'(error_o), 80'(1));
        check("bad_recv", 80'(recv_count_o), 80'(4));
        check("bad_sig", 80'(signature_o), 80'(m_sig));

        // Timeout with a silent client.
        start_run();
        send_one();
        cnt = 0;
        while (!done_o && cnt < 40) begin
            tick();
            cnt++;
        end
        check("timeout_cycles", 80'(cnt), 80'(16));
        check("timeout_err", 80'(error_o), 80'(1));
        check("timeout_sent", 80'(sent_count_o), 80'(1));
        check("timeout_recv", 80'(recv_count_o), 80'(0));

        // Reset mid-run.
        start_run();
        send_one();
        send_one();
        #3 reset_i = 1'b0;
        #1;
        check("mid_rst_v", 80'(v_o), 80'(0));
        check("mid_rst_data", data_o, 80'(0));
        check("mid_rst_ready", 80'(ready_o), 80'(0));
        check("mid_rst_sent", 80'(sent_count_o), 80'(0));
        check("mid_rst_sig", 80'(signature_o), 80'(0));
        tick();
        #2 reset_i = 1'b1;
        tick();
        start_run();
        check("post_rst_payload", 80'(data_o[63:0]), 80'(SEED));
        send_one();
        respond(echo(last_payload[31:0]));
        check("post_rst_recv", 80'(recv_count_o), 80'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
